// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter that lends one up/down counter to two requesters for a run of N steps,
// keeping a shadow of the counter value and pulsing done when a run completes.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// SETUP | owner granted, mode latched, counter idle for one cycle
// RUN   | cnt_en high, one step per cycle until remaining is exhausted
// DONE  | done pulse to owner, pointer passes to the other requester
module updown_counter_arbiter #(
    parameter int WIDTH = 3,
    parameter int STEPW = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [STEPW-1:0] steps0,
    input  logic [STEPW-1:0] steps1,
    output logic             grant0,
    output logic             grant1,
    output logic             done0,
    output logic             done1,
    output logic             cnt_mode,
    output logic             cnt_en,
    output logic             busy,
    output logic [WIDTH-1:0] pos
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t           state, state_n;
    logic             ptr, ptr_n;
    logic             owner, owner_n;
    logic [STEPW-1:0] rem, rem_n;
    logic             grant0_n, grant1_n, done0_n, done1_n;
    logic             cnt_mode_n, cnt_en_n, busy_n;
    logic [WIDTH-1:0] pos_n;
    logic             pick;
    logic             own_req;

    // Contention goes to the pointer; a lone request wins outright.
    assign pick    = (req0 && req1) ? ptr : req1;
    assign own_req = owner ? req1 : req0;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            rem      <= '0;
            grant0   <= 1'b0;
            grant1   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            cnt_mode <= 1'b0;
            cnt_en   <= 1'b0;
            busy     <= 1'b0;
            pos      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            rem      <= rem_n;
            grant0   <= grant0_n;
            grant1   <= grant1_n;
            done0    <= done0_n;
            done1    <= done1_n;
            cnt_mode <= cnt_mode_n;
            cnt_en   <= cnt_en_n;
            busy     <= busy_n;
            pos      <= pos_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        rem_n      = rem;
        grant0_n   = grant0;
        grant1_n   = grant1;
        done0_n    = 1'b0;
        done1_n    = 1'b0;
        cnt_mode_n = cnt_mode;
        cnt_en_n   = 1'b0;
        pos_n      = pos;

        // Shadow follows the counter: it moves on every edge that sees cnt_en high.
        if (cnt_en) begin
            pos_n = cnt_mode ? (pos - WIDTH'(1)) : (pos + WIDTH'(1));
        end

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_n    = pick;
                    grant0_n   = !pick;
                    grant1_n   = pick;
                    cnt_mode_n = pick ? dir1 : dir0;
                    rem_n      = pick ? steps1 : steps0;
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                if (!own_req) begin
                    state_n  = IDLE;
                    grant0_n = 1'b0;
                    grant1_n = 1'b0;
                    ptr_n    = !owner;
                end else if (rem == '0) begin
                    state_n = DONE;
                    done0_n = !owner;
                    done1_n = owner;
                end else begin
                    state_n  = RUN;
                    cnt_en_n = 1'b1;
                end
            end
            RUN: begin
                if (!own_req) begin
                    state_n  = IDLE;
                    grant0_n = 1'b0;
                    grant1_n = 1'b0;
                    ptr_n    = !owner;
                end else if (rem == STEPW'(1)) begin
                    state_n = DONE;
                    rem_n   = '0;
                    done0_n = !owner;
                    done1_n = owner;
                end else begin
                    rem_n    = rem - STEPW'(1);
                    cnt_en_n = 1'b1;
                end
            end
            DONE: begin
                state_n  = IDLE;
                grant0_n = 1'b0;
                grant1_n = 1'b0;
                ptr_n    = !owner;
            end
            default: begin
                state_n  = IDLE;
                grant0_n = 1'b0;
                grant1_n = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: doc/updown_counter_arbiter.md
Name: updown_counter_arbiter

Overview:
Controller that shares one WIDTH-bit up/down counter datapath between two requesters. Each requester asks for a run of N count steps in a chosen direction. The arbiter grants round-robin and drives the counter's mode and count-enable for exactly N cycles. It keeps a shadow copy of the counter value and signals completion per requester.

Parameters:
WIDTH, 3, counter width; also the width of the shadow position pos.
STEPW, 3, width of the step-count request fields.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clear  input  1  asynchronous, active-low reset.
req0  input  1  requester 0 run request; level, held until done0 or abandoned.
req1  input  1  requester 1 run request; same rules as req0.
dir0  input  1  requester 0 direction; 0 = up, 1 = down. Sampled at grant.
dir1  input  1  requester 1 direction; same encoding as dir0.
steps0  input  STEPW  requester 0 step count. Sampled at grant.
steps1  input  STEPW  requester 1 step count. Sampled at grant.
grant0  output  1  requester 0 owns the counter.
grant1  output  1  requester 1 owns the counter.
done0  output  1  one-cycle pulse: requester 0 run completed.
done1  output  1  one-cycle pulse: requester 1 run completed.
cnt_mode  output  1  counter mode; 0 = up, 1 = down.
cnt_en  output  1  counter advances one step on the next clk edge when high.
busy  output  1  high in any state other than IDLE.
pos  output  WIDTH  shadow counter value.

Behaviour:
- Reset (clear=0, asynchronous):
  - state = IDLE.
  - grant0, grant1, done0, done1, cnt_en, cnt_mode, busy = 0.
  - pos = 0, matching the cleared counter.
  - Round-robin pointer = 0, so requester 0 has priority first.
- All outputs are registered.
- States: IDLE, SETUP, RUN, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester the pointer selects.
  - On grant: latch dir into cnt_mode, latch steps into a remaining-count register, assert grant_x, go to SETUP.
- SETUP (one cycle): cnt_mode is stable and cnt_en = 0, giving the counter one cycle to settle mode before it counts.
  - remaining = 0: go to DONE with no count pulses.
  - Otherwise: go to RUN with cnt_en = 1.
- RUN:
  - cnt_en = 1 every cycle. Each cycle decrement remaining and step pos (+1 for up, -1 for down).
  - pos wraps modulo 2^WIDTH: up from 7 gives 0; down from 0 gives 7.
  - When remaining reaches 1 in the current cycle, the next state is DONE and cnt_en is 0 in DONE.
  - cnt_en is high for exactly steps cycles.
- DONE (one cycle):
  - done_x = 1, grant_x still 1, cnt_en = 0.
  - Pointer moves to the other requester.
  - Next state is IDLE with grant_x = 0.
- Latency: req seen in IDLE at edge k gives:
  - grant at k+1;
  - cnt_en high for edges k+2 .. k+1+N;
  - done at k+2+N;
  - back in IDLE at k+3+N.
  - For N = 0, done is at k+2.
- Abort: if the granted requester drops req in SETUP or RUN:
  - next cycle cnt_en = 0, grant = 0, state = IDLE, no done pulse;
  - pointer moves to the other requester;
  - pos keeps the steps actually issued.
- Non-granted requests are ignored until IDLE. Input changes on dir or steps after grant are ignored.
- Back-to-back: a requester still asserting req in DONE is treated as a new request in IDLE. If both requesters are asking, the other one wins because the pointer has moved.
- grant0 and grant1 are never both high. At most one done pulse occurs per cycle.
- Reset mid-run: all outputs return to reset values immediately, asynchronously.

Test Plan:
- Reset, then req0 = 1, dir0 = 0, steps0 = 3, pos = 0 -> grant0 the next cycle; cnt_en high for 3 cycles; pos 1, 2, 3; done0 pulse; busy drops after.
- Start from pos = 1; req1 = 1, dir1 = 1, steps1 = 4 -> cnt_mode = 1; pos 0, 7, 6, 5 (wrap); done1 after exactly 4 cnt_en cycles.
- From reset, req0 and req1 both held high with steps = 2 -> grant order 0, 1, 0, 1. Grants never overlap; each done alternates.
- req0 with steps0 = 0 -> grant0, SETUP, done0; no cnt_en pulse; pos unchanged.
- req0 with steps0 = 5; drop req0 after 2 cnt_en cycles -> cnt_en low the next cycle; no done0; pos advanced by exactly 2; a pending req1 is granted next.
- Assert clear = 0 mid-RUN, asynchronously with no clk edge -> all outputs 0 and pos = 0 immediately. After release, state is IDLE and requester 0 has priority.
